// File: rtl/snake_ctrl.sv
// snake_ctrl: button edge arbitration, move-step timing and game FSM.
// Optional SNAKE_CTRL_SPEEDUP_EN: step period shrinks as score grows.
module snake_ctrl #(
  parameter int TICK_DIV = 5000000,
  parameter int MIN_DIV  = 1000000,
  parameter int DIV_STEP = 250000,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left,
  input  logic               right,
  input  logic               up,
  input  logic               down,
  input  logic               start,
  input  logic               collide,
  input  logic               ate,
  output logic               step,
  output logic [1:0]         dir,
  output logic               grow,
  output logic               clear,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_OVER  = 2'b11;

  localparam logic [1:0] D_RIGHT = 2'b00;
  localparam logic [1:0] D_LEFT  = 2'b01;
  localparam logic [1:0] D_UP    = 2'b10;
  localparam logic [1:0] D_DOWN  = 2'b11;

  localparam logic [31:0]        TICK32    = 32'(TICK_DIV);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [4:0]  btn;
  logic [4:0]  btn_q;
  logic [4:0]  edge_q;
  logic [1:0]  pend_dir;
  logic        grow_pend;
  logic [31:0] cnt;
  logic [31:0] cur_div;
  logic        e_start;
  logic        dir_hit;
  logic [1:0]  dir_win;
  logic        dir_ok;
  logic        gp_next;
  logic        wrap;

  assign btn = {start, up, down, left, right};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q  <= '0;
      edge_q <= '0;
    end else begin
      btn_q  <= btn;
      edge_q <= btn & ~btn_q;
    end
  end

  assign e_start = edge_q[4];
  assign dir_hit = |edge_q[3:0];

  always_comb begin
    dir_win = D_RIGHT;
    if (edge_q[3])      dir_win = D_UP;
    else if (edge_q[2]) dir_win = D_DOWN;
    else if (edge_q[1]) dir_win = D_LEFT;
  end

  // reverse heading differs only in bit 0 (right/left, up/down)
  assign dir_ok = dir_hit && (dir_win != (dir ^ 2'b01));

`ifdef SNAKE_CTRL_SPEEDUP_EN
  localparam logic [31:0] MIN32 = 32'(MIN_DIV);
  logic [31:0] prod;
  logic [31:0] diff;
  assign prod = 32'(score) * 32'(DIV_STEP);
  assign diff = TICK32 - prod;
  always_comb begin
    cur_div = diff;
    if (prod > TICK32 || diff < MIN32) cur_div = MIN32;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(MIN_DIV), 32'(DIV_STEP)};
  assign cur_div = TICK32;
`endif

  // ate in the step cycle still refers to the cell just consumed
  assign gp_next = grow_pend | (ate & ~step);
  assign wrap    = cnt >= (cur_div - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      step      <= 1'b0;
      clear     <= 1'b0;
      grow      <= 1'b0;
      dir       <= D_RIGHT;
      pend_dir  <= D_RIGHT;
      grow_pend <= 1'b0;
      score     <= '0;
      cnt       <= '0;
    end else begin
      step  <= 1'b0;
      clear <= 1'b0;
      grow  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (e_start || dir_hit) begin
            state <= S_RUN;
            clear <= 1'b1;
            cnt   <= '0;
            if (dir_ok) pend_dir <= dir_win;
          end
        end
        S_RUN: begin
          if (collide) begin
            state <= S_OVER;
          end else if (e_start) begin
            state <= S_PAUSE;
          end else begin
            if (dir_ok) pend_dir <= dir_win;
            if (wrap) begin
              cnt       <= '0;
              step      <= 1'b1;
              dir       <= pend_dir;
              grow      <= gp_next;
              grow_pend <= 1'b0;
              if (gp_next && score != SCORE_MAX)
                score <= score + SCORE_W'(1);
            end else begin
              cnt       <= cnt + 32'd1;
              grow_pend <= gp_next;
            end
          end
        end
        S_PAUSE: begin
          if (e_start) state <= S_RUN;
        end
        S_OVER: begin
          if (e_start) begin
            state     <= S_RUN;
            clear     <= 1'b1;
            score     <= '0;
            cnt       <= '0;
            grow_pend <= 1'b0;
            dir       <= D_RIGHT;
            pend_dir  <= D_RIGHT;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/snake_ctrl.md
# snake_ctrl

Game sequencer for the snake design: sits between the debounced direction buttons and the snake model. Turns button edges into a single arbitrated, reversal-safe heading, generates the move-step strobe that advances the model, and runs the game state machine (idle / run / pause / over). It also keeps the score, which can optionally shorten the step period as the game progresses.

## Interface
Parameters:
- TICK_DIV, 5000000: base step period in clk cycles (20 Hz at 100 MHz); minimum 2
- MIN_DIV, 1000000: floor on step period when speed-up is enabled; 2 <= MIN_DIV <= TICK_DIV
- DIV_STEP, 250000: period reduction per score point (speed-up only)
- SCORE_W, 8: score width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- left, right, up, down  in  1 each  debounced button levels, active-high
- start  in  1  debounced start/pause button level, active-high
- collide  in  1  model flag: head hit wall or body, level
- ate  in  1  model flag: head on food, level, held until next step
- step  out  1  one-cycle strobe: model advances one cell
- dir  out  2  heading: 00 right, 01 left, 10 up, 11 down
- grow  out  1  qualifies step: append segment this move
- clear  out  1  one-cycle strobe: model reinitialises snake and food
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
- score  out  SCORE_W  foods eaten this game

## Operation
- All five buttons pass through internal rising-edge detectors (previous-level registers reset to 0); only edges act.
- Direction arbitration: same-cycle edges resolved by priority up > down > left > right. The winner is written to `pend_dir` unless it is the reverse of the committed `dir`. Reversal is checked against `dir`, not `pend_dir`. Later edges before a step overwrite `pend_dir`.
- `dir` loads `pend_dir` in the same cycle `step` is asserted, so the model samples the new heading with the strobe.
- Food: an `ate` level seen in RUN sets `grow_pend` once per step interval. On the next step, `grow` = 1 with `step`; at the same edge `score` increments, saturating at 2^SCORE_W-1, and `grow_pend` clears.
- FSM transitions:
  - IDLE -> RUN on a start edge or any direction edge. Pulse `clear`, zero the counter.
  - RUN -> PAUSE on a start edge.
  - RUN -> OVER when `collide` is 1.
  - PAUSE -> RUN on a start edge. The counter is held, not cleared.
  - OVER -> RUN on a start edge. Pulse `clear`, zero score and counter, drop `grow_pend`, set `dir` and `pend_dir` to 00.
  - Direction edges in PAUSE and OVER are ignored.
- Step counter: 32-bit, counts only in RUN. When it reaches `cur_div`-1 it wraps to 0 and `step` pulses.

## Timing
- Reset values: step 0, dir 00, grow 0, clear 0, state 00, score 0. Also pend_dir 00 and counter 0.
- Button edge to `pend_dir` update: 2 cycles (edge register, then arbitration register).
- `step` is high exactly 1 cycle. `dir` and `grow` are valid in that cycle. `dir` is stable between steps. `grow` is 0 whenever `step` is 0.
- First `step` after entering RUN from IDLE or OVER comes `cur_div` cycles after the `clear` pulse. `clear` coincides with the state register changing to RUN.
- Simultaneous events:
  - `collide` and a start edge in RUN: go to OVER.
  - `collide` and a step wrap in the same cycle: `step` is suppressed.
  - `collide` and `ate` together: go to OVER, score unchanged.
  - `collide` outside RUN is ignored.
- Reset asserted mid-game forces all registers to their reset values on the next sampled reset level, regardless of state.

## Configuration
- SNAKE_CTRL_SPEEDUP_EN defined: `cur_div` = max(MIN_DIV, TICK_DIV - score*DIV_STEP). Compute at 32 bits; if the product exceeds TICK_DIV the result clamps to MIN_DIV. `cur_div` is re-evaluated at each step.
- SNAKE_CTRL_SPEEDUP_EN undefined: `cur_div` = TICK_DIV constant; MIN_DIV and DIV_STEP are unused.

## Test plan
Bench parameters: TICK_DIV=10, MIN_DIV=4, DIV_STEP=2, SCORE_W=4.
- Reset, then up edge in IDLE -> `clear` 1 cycle, state=01; `step` pulses 10 cycles later with dir=10, then every 10 cycles.
- dir=00 (right), press left -> `pend_dir` unchanged, next step dir=00. Then press up and left in the same cycle -> next step dir=10.
- Hold `ate` for 3 cycles within one interval -> exactly one step with grow=1 and score 0->1. Repeat to 15, then one more -> score stays 15.
- Start edge in RUN at counter=6 -> state=10, no steps. Start edge again -> state=01, next step 4 cycles later.
- `collide`=1 the same cycle as a step wrap, with `ate`=1 -> state=11, no step, score unchanged. Start edge -> clear pulse, score=0, dir=00, state=01.
- With SNAKE_CTRL_SPEEDUP_EN: step spacing 10, 8, 6, 4, 4 cycles as score goes 0, 1, 2, 3, 4. Without the macro: always 10.
